issue_scheduler: RTL and testbench
==================================

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_RS, default 16, meaning the number of reservation-station rows (power of two).
REQ-002 The block SHALL have parameter NUM_FU, default 3, meaning the number of functional units (FU codes 0..NUM_FU-1).
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, meaning the asynchronous, active-low reset.
REQ-005 The block SHALL have port flush, input, 1, meaning a synchronous squash of all in-flight grants.
REQ-006 The block SHALL have port rs_req, input, NUM_RS, meaning row e is in use with both sources ready.
REQ-007 The block SHALL have port rs_fu, input, 2*NUM_RS, meaning the FU code of row e at bits [2e+1:2e]; code 3 is never issued.
REQ-008 The block SHALL have port fu_ready, input, NUM_FU, meaning FU f accepts an instruction this cycle.
REQ-009 The block SHALL have port fu_valid, output, NUM_FU, meaning a registered grant is presented to FU f.
REQ-010 The block SHALL have port fu_idx, output, 4*NUM_FU, meaning the granted RS row for FU f at bits [4f+3:4f].
REQ-011 The block SHALL have port rs_clear, output, NUM_RS, meaning row e was accepted by an FU this cycle and is freed at the next edge.
REQ-012 The block SHALL have port issue_cnt, output, 16, meaning the running count of accepted issues.

Function
REQ-013 Row e SHALL be eligible for FU f when rs_req[e]=1, rs_fu[e]=f, and held[e]=0, where held is an internal NUM_RS mask.
REQ-014 Each FU SHALL have its own 4-bit round-robin pointer ptr[f]; the winner SHALL be the first eligible row found scanning ptr[f], ptr[f]+1, ... mod NUM_RS.
REQ-015 The output slot of FU f SHALL load only when fu_valid[f]=0 or fu_ready[f]=1.
REQ-016 When the slot loads and a winner exists, fu_valid[f] SHALL become 1, fu_idx[f] SHALL take the winner, held[winner] SHALL be set, and ptr[f] SHALL become winner+1, wrapping 15 to 0.
REQ-017 When the slot loads and no winner exists, fu_valid[f] SHALL become 0 and ptr[f] SHALL be unchanged.
REQ-018 While fu_valid[f]=1 and fu_ready[f]=0, fu_valid[f] and fu_idx[f] SHALL hold stable.
REQ-019 A grant SHALL fire when fu_valid[f]=1 and fu_ready[f]=1.
REQ-020 rs_clear[e] SHALL be combinational and equal 1 exactly when some FU fires with fu_idx[f]=e.
REQ-021 On the same edge as a firing grant, held[e] SHALL clear.
REQ-022 The fired row SHALL be excluded from selection on that edge, because held[e] is still 1 during the selection cycle.
REQ-023 Back-to-back grants SHALL have no bubble: a fire plus a new winner in one cycle yields fu_valid[f]=1 with the new index on the next cycle.
REQ-024 Grant latency SHALL be one cycle: a row eligible in cycle N with the slot free is presented in cycle N+1.
REQ-025 All FUs SHALL select in the same cycle, with at most NUM_FU grants per cycle; rows are partitioned by FU code, so no row is granted twice.
REQ-026 issue_cnt SHALL add the number of fires each cycle (0..NUM_FU), modulo 2^16 (wraps from 65535).
REQ-027 If rs_req[e] drops while row e is held but not fired, the grant SHALL remain valid; the RS owner guarantees rows are not withdrawn without a flush.
REQ-028 flush=1 SHALL, at the next edge, clear fu_valid and held, and no new grants SHALL be made on that edge.
REQ-029 rs_clear SHALL be forced to 0 while flush=1.
REQ-030 flush SHALL retain ptr[f] and issue_cnt.
REQ-031 flush SHALL take priority over fire and over select.

Reset
REQ-032 On rst_n=0, asynchronously: fu_valid=0, fu_idx=0, held=0, ptr[f]=0, issue_cnt=0; rs_clear is therefore 0.
REQ-033 Reset asserted mid-grant SHALL discard the grant without asserting rs_clear.
REQ-034 After rst_n deasserts, the first grant SHALL occur at the first rising edge with an eligible row.

Verification
REQ-035 Reset, then rs_req=0x0001, rs_fu row0=0, fu_ready=1 -> next cycle fu_valid[0]=1, fu_idx[0]=0 and rs_clear=0x0001; following cycle (RS cleared row) fu_valid[0]=0, issue_cnt=1.
REQ-036 Rows 2, 5 and 14 all FU1 and ready, fu_ready[1]=1 held high -> grants in order 2, 5, 14 on consecutive cycles, then ptr[1]=15; row 0 requested next -> granted (wrap).
REQ-037 Row 3 FU0 with fu_ready[0]=0 for 4 cycles -> fu_valid[0]=1, fu_idx[0]=3 stable, rs_clear=0, row 3 never regranted; fu_ready[0]=1 -> rs_clear=0x0008 for exactly one cycle.
REQ-038 Rows 0/1/2 with FU codes 0/1/2, all fu_ready=1 -> all three fu_valid=1 in the same cycle, issue_cnt increases by 3; a row with code 3 is never granted.
REQ-039 Grant pending on FU2 with fu_ready[2]=0, then flush=1 for one cycle -> fu_valid=0, rs_clear=0, issue_cnt unchanged, ptr[2] retained.
REQ-040 rst_n pulsed low mid-stall -> all outputs 0 immediately, without waiting for clk.
REQ-041 issue_cnt preloaded near 65535 by 65534 fires, then 3 simultaneous fires -> issue_cnt=1.

Source files
------------

// File: rtl/issue_scheduler.sv
// Per-FU round-robin issue selection with one registered grant slot per FU.
// A row is held from grant until its FU accepts it, so it is never granted twice.
module issue_scheduler #(
  parameter int NUM_RS = 16,
  parameter int NUM_FU = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [NUM_RS-1:0]     rs_req,
  input  logic [2*NUM_RS-1:0]   rs_fu,
  input  logic [NUM_FU-1:0]     fu_ready,
  output logic [NUM_FU-1:0]     fu_valid,
  output logic [4*NUM_FU-1:0]   fu_idx,
  output logic [NUM_RS-1:0]     rs_clear,
  output logic [15:0]           issue_cnt
);

  localparam logic [3:0] IDX_MASK = 4'(NUM_RS - 1);

  logic [NUM_FU-1:0]      r_valid;
  logic [NUM_FU-1:0][3:0] r_idx;
  logic [NUM_FU-1:0][3:0] r_ptr;
  logic [NUM_RS-1:0]      r_held;
  logic [15:0]            r_cnt;

  logic [NUM_FU-1:0]      w_fire;
  logic [NUM_FU-1:0]      w_load;
  logic [NUM_FU-1:0]      w_found;
  logic [NUM_FU-1:0][3:0] w_win;
  logic [NUM_RS-1:0]      w_clr;
  logic [NUM_RS-1:0]      w_set;
  logic [15:0]            w_nfire;

  assign w_fire = r_valid & fu_ready;
  assign w_load = ~r_valid | fu_ready;

  // Scan from each FU's pointer; held rows (including one firing now) are skipped.
  always_comb begin
    logic [3:0] v_scan;
    w_found = '0;
    w_win   = '0;
    v_scan  = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      for (int k = 0; k < NUM_RS; k++) begin
        v_scan = 4'(r_ptr[f] + 4'(k)) & IDX_MASK;
        if (!w_found[f] && rs_req[v_scan] && !r_held[v_scan] &&
            (rs_fu[2*v_scan +: 2] == 2'(f))) begin
          w_found[f] = 1'b1;
          w_win[f]   = v_scan;
        end
      end
    end
  end

  always_comb begin
    w_clr   = '0;
    w_set   = '0;
    w_nfire = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      if (w_fire[f]) begin
        w_clr[r_idx[f]] = 1'b1;
        w_nfire         = w_nfire + 16'(w_fire[f]);
      end
      if (w_load[f] && w_found[f]) begin
        w_set[w_win[f]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_held  <= '0;
      r_cnt   <= '0;
    end else if (flush) begin
      r_valid <= '0;
      r_held  <= '0;
    end else begin
      r_held <= (r_held & ~w_clr) | w_set;
      r_cnt  <= r_cnt + w_nfire;
      for (int f = 0; f < NUM_FU; f++) begin
        if (w_load[f]) begin
          r_valid[f] <= w_found[f];
          if (w_found[f]) begin
            r_idx[f] <= w_win[f];
            r_ptr[f] <= 4'(w_win[f] + 4'd1) & IDX_MASK;
          end
        end
      end
    end
  end

  always_comb begin
    fu_idx = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      fu_idx[4*f +: 4] = r_idx[f];
    end
  end

  assign fu_valid  = r_valid;
  assign rs_clear  = flush ? '0 : w_clr;
  assign issue_cnt = r_cnt;

endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboard bench for issue_scheduler: stimulus queues expected fires, a monitor pops them.
module tb_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [15:0] rs_req;
  logic [31:0] rs_fu;
  logic [2:0]  fu_ready;
  logic [2:0]  fu_valid;
  logic [11:0] fu_idx;
  logic [15:0] rs_clear;
  logic [15:0] issue_cnt;

  always #5 clk = ~clk;

  issue_scheduler #(.NUM_RS(16), .NUM_FU(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .rs_req    (rs_req),
    .rs_fu     (rs_fu),
    .fu_ready  (fu_ready),
    .fu_valid  (fu_valid),
    .fu_idx    (fu_idx),
    .rs_clear  (rs_clear),
    .issue_cnt (issue_cnt)
  );

  typedef struct packed {
    logic [1:0] fu;
    logic [3:0] idx;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int fu, input int idx);
    exp_t e;
    e.fu  = 2'(fu);
    e.idx = 4'(idx);
    q.push_back(e);
  endtask

  task automatic set_code(input int row, input int code);
    rs_fu[2*row +: 2] = 2'(code);
  endtask

  // One cycle; with drop set, rows cleared this cycle are withdrawn after the edge.
  task automatic tick(input bit drop);
    logic [15:0] clr;
    @(negedge clk);
    clr = rs_clear;
    @(posedge clk);
    #1;
    if (drop) rs_req = rs_req & ~clr;
  endtask

  // Monitor: every accepted grant must match the head of the queue.
  initial begin
    logic [15:0] mask;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        mask = '0;
        for (int f = 0; f < 3; f++) begin
          if (fu_valid[f] && fu_ready[f] && !flush) begin
            mask[fu_idx[4*f +: 4]] = 1'b1;
            if (q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL spurious_fire: fu=%0d idx=%0d, expected no fire", f, fu_idx[4*f +: 4]);
            end else begin
              e = q.pop_front();
              chk("fire_fu", 32'(f), 32'(e.fu));
              chk("fire_idx", 32'(fu_idx[4*f +: 4]), 32'(e.idx));
            end
          end
        end
        chk("rs_clear", 32'(rs_clear), 32'(mask));
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    rs_req   = '0;
    rs_fu    = '1;
    fu_ready = '0;
    #12;
    chk("rst_valid", 32'(fu_valid), 32'd0);
    chk("rst_idx", 32'(fu_idx), 32'd0);
    chk("rst_clear", 32'(rs_clear), 32'd0);
    chk("rst_cnt", 32'(issue_cnt), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single grant on FU0, one-cycle latency
    fu_ready = 3'b111;
    set_code(0, 0);
    rs_req = 16'h0001;
    push(0, 0);
    tick(1);
    chk("t1_valid", 32'(fu_valid), 32'd1);
    chk("t1_idx", 32'(fu_idx[3:0]), 32'd0);
    chk("t1_clear", 32'(rs_clear), 32'h1);
    tick(1);
    chk("t1_cnt", 32'(issue_cnt), 32'd1);
    chk("t1_valid_off", 32'(fu_valid), 32'd0);

    // Round robin on FU1, then wrap from pointer 15
    rs_fu = '1;
    set_code(2, 1); set_code(5, 1); set_code(14, 1);
    rs_req = 16'h4024;
    push(1, 2); push(1, 5); push(1, 14);
    repeat (4) tick(1);
    chk("t2_idle", 32'(fu_valid), 32'd0);
    set_code(0, 1); set_code(15, 1);
    rs_req = 16'h8001;
    push(1, 15); push(1, 0);
    repeat (3) tick(1);
    chk("t2_idle2", 32'(fu_valid), 32'd0);
    chk("t2_cnt", 32'(issue_cnt), 32'd6);

    // Stall on FU0
    rs_fu = '1;
    set_code(3, 0);
    fu_ready = 3'b110;
    rs_req = 16'h0008;
    tick(1);
    repeat (4) begin
      chk("t3_stall_valid", 32'(fu_valid[0]), 32'd1);
      chk("t3_stall_idx", 32'(fu_idx[3:0]), 32'd3);
      chk("t3_stall_clear", 32'(rs_clear), 32'd0);
      tick(1);
    end
    push(0, 3);
    fu_ready = 3'b111;
    #1;
    chk("t3_clear", 32'(rs_clear), 32'h8);
    tick(1);
    chk("t3_clear_once", 32'(rs_clear), 32'd0);
    chk("t3_valid_off", 32'(fu_valid), 32'd0);
    chk("t3_cnt", 32'(issue_cnt), 32'd7);

    // All three FUs in one cycle; code 3 never issued
    rs_fu = '1;
    set_code(0, 0); set_code(1, 1); set_code(2, 2);
    rs_req = 16'h0017;
    push(0, 0); push(1, 1); push(2, 2);
    tick(1);
    chk("t4_valid", 32'(fu_valid), 32'd7);
    tick(1);
    chk("t4_cnt", 32'(issue_cnt), 32'd10);
    repeat (2) tick(1);
    chk("t4_code3", 32'(fu_valid), 32'd0);
    rs_req = '0;

    // Flush with a pending FU2 grant; pointer survives the flush
    rs_fu = '1;
    set_code(6, 2);
    fu_ready = 3'b011;
    rs_req = 16'h0040;
    tick(1);
    chk("t5_valid", 32'(fu_valid), 32'd4);
    chk("t5_idx", 32'(fu_idx[11:8]), 32'd6);
    flush = 1'b1;
    fu_ready = 3'b111;
    #1;
    chk("t5_flush_clear", 32'(rs_clear), 32'd0);
    tick(1);
    flush = 1'b0;
    chk("t5_flush_valid", 32'(fu_valid), 32'd0);
    chk("t5_flush_cnt", 32'(issue_cnt), 32'd10);
    set_code(9, 2);
    rs_req = rs_req | 16'h0200;
    push(2, 9); push(2, 6);
    repeat (3) tick(1);
    chk("t5_cnt", 32'(issue_cnt), 32'd12);

    // Asynchronous reset during a stall
    rs_fu = '1;
    set_code(7, 0);
    fu_ready = 3'b110;
    rs_req = 16'h0080;
    tick(1);
    chk("t6_valid", 32'(fu_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(fu_valid), 32'd0);
    chk("t6_rst_idx", 32'(fu_idx), 32'd0);
    chk("t6_rst_clear", 32'(rs_clear), 32'd0);
    chk("t6_rst_cnt", 32'(issue_cnt), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(1);
    chk("t6_regrant", 32'(fu_valid), 32'd1);
    chk("t6_regrant_idx", 32'(fu_idx[3:0]), 32'd7);
    fu_ready = 3'b111;
    push(0, 7);
    tick(1);
    chk("t6_cnt", 32'(issue_cnt), 32'd1);

    // Bulk back-to-back streaming to drive the counter to its wrap point
    rs_fu = '1;
    set_code(0, 0); set_code(1, 0);
    set_code(2, 1); set_code(3, 1);
    set_code(4, 2); set_code(5, 2);
    for (int k = 0; k < 21844; k++) begin
      push(0, k % 2); push(1, 2 + k % 2); push(2, 4 + k % 2);
    end
    fu_ready = 3'b111;
    rs_req = 16'h003F;
    tick(0);
    repeat (21844) tick(0);
    fu_ready = 3'b000;
    rs_req = '0;
    flush = 1'b1;
    tick(0);
    flush = 1'b0;
    chk("t7_bulk_cnt", 32'(issue_cnt), 32'd65533);
    fu_ready = 3'b111;
    rs_req = 16'h0001;
    push(0, 0);
    tick(1);
    tick(1);
    chk("t7_cnt_65534", 32'(issue_cnt), 32'd65534);
    rs_req = 16'h0015;
    push(0, 0); push(1, 2); push(2, 4);
    tick(1);
    tick(1);
    chk("t7_wrap_cnt", 32'(issue_cnt), 32'd1);
    chk("t7_idle", 32'(fu_valid), 32'd0);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
